// File: rtl/imem_loader.sv
// UART boot loader: assembles little-endian words from a byte stream and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] word_cnt;
    logic [1:0]  idx;
    logic [23:0] lanes;
    logic        write_fire;
    logic [15:0] count_full;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign count_full = {rx_data, count[7:0]};
    assign last_word  = (word_cnt == count - 16'd1);

    // Status outputs decode directly from the registered state.
    assign done     = (state == DONE);
    assign error    = (state == ERROR);
    assign cpu_hold = (state != DONE);

    always_comb begin
        state_next = state;
        write_fire = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE, ERROR: if (rx_data == HEADER) state_next = CNT_LO;
                CNT_LO:      state_next = CNT_HI;
                CNT_HI: begin
                    if (count_full == '0 || {16'd0, count_full} > MAX_WORDS)
                        state_next = ERROR;
                    else
                        state_next = DATA;
                end
                DATA: begin
                    if (idx == 2'd3) begin
                        write_fire = 1'b1;
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_next = CHK;
`else
                            state_next = DONE;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: state_next = (rx_data == csum) ? DONE : ERROR;
`endif
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            word_cnt   <= '0;
            idx        <= '0;
            lanes      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state   <= state_next;
            imem_we <= write_fire;
            if (rx_valid) begin
                case (state)
                    IDLE, ERROR: begin
                        if (rx_data == HEADER) begin
                            word_cnt <= '0;
                            idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                        end
                    end
                    CNT_LO: count[7:0] <= rx_data;
                    CNT_HI: begin
                        count[15:8] <= rx_data;
                        word_cnt    <= '0;
                        idx         <= '0;
                    end
                    DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        idx <= idx + 2'd1;
                        // Byte 3 goes straight to the write register, so the pulse for
                        // this word overlaps byte 0 of the next without a holding stage.
                        case (idx)
                            2'd0: lanes[7:0]   <= rx_data;
                            2'd1: lanes[15:8]  <= rx_data;
                            2'd2: lanes[23:16] <= rx_data;
                            default: begin
                                imem_wdata <= {rx_data, lanes};
                                imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                                word_cnt   <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; write scoreboard fed at stimulus time, drained by a write monitor.
// Covers both builds of IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    int          wr_start;
    logic        prev_we = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [7:0]  tx_q[$];
    logic [7:0]  xsum;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(512)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write monitor: every pulse must match the head of the scoreboard and last one cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h required=no write", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL write addr/data=%h/%h required=%h/%h",
                             imem_addr, imem_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
            checks++;
            if (prev_we) begin
                failures++;
                $display("FAIL we_pulse_width we high on consecutive cycles, required one cycle");
            end
        end
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input int gap);
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    task automatic add_header(input logic [15:0] n);
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        xsum = 8'h00;
    endtask

    task automatic add_word(input logic [31:0] w, input int index);
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(w[8*i +: 8]);
            xsum = xsum ^ w[8*i +: 8];
        end
        exp_q.push_back({BASE + 32'(4 * index), w});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b0, BASE, 32'h0}) begin
            failures++;
            $display("FAIL reset_write_port we/addr/data=%b/%h/%h required=0/%h/0", imem_we, imem_addr, imem_wdata, BASE);
        end
        checks++;
        if ({done, cpu_hold, error} !== 3'b010) begin
            failures++;
            $display("FAIL reset_status done/hold/err=%b required=010", {done, cpu_hold, error});
        end
        do_reset();
    endtask

    // Sends the two-word frame; the final byte is sent alone so its edge can be inspected.
    task automatic run_two_word(input string name, input int gap, input logic [7:0] chk, input logic exp_ok);
        logic [7:0] last;
        wr_start = wr_count;
        add_header(16'd2);
        add_word(32'h0000_0013, 0);
        add_word(32'h0010_0093, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(chk);
`endif
        last = tx_q.pop_back();
        send_q(gap);
        checks++;
        if ({done, cpu_hold, error} !== 3'b010) begin
            failures++;
            $display("FAIL %s_before_last done/hold/err=%b required=010", name, {done, cpu_hold, error});
        end
        send_byte(last);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (imem_we !== 1'b1) begin
            failures++;
            $display("FAIL %s_final_we we=%b required=1 with done", name, imem_we);
        end
`endif
        checks++;
        if ({done, cpu_hold, error} !== (exp_ok ? 3'b100 : 3'b011)) begin
            failures++;
            $display("FAIL %s_status done/hold/err=%b required=%b", name, {done, cpu_hold, error}, exp_ok ? 3'b100 : 3'b011);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_count - wr_start !== 2 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s_write_count writes=%0d pending=%0d required=2/0", name, wr_count - wr_start, exp_q.size());
        end
    endtask

    task automatic test_valid_frame();
        do_reset();
        run_two_word("valid", 1, 8'h90, 1'b1);
    endtask

    task automatic test_bad_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        run_two_word("badchk", 1, 8'h91, 1'b0);
        run_two_word("recover", 1, 8'h90, 1'b1);
`else
        // Without the checksum the trailing byte is ignored in DONE.
        do_reset();
        run_two_word("valid_nochk", 1, 8'h00, 1'b1);
        wr_start = wr_count;
        send_byte(8'h22);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, cpu_hold, error} !== 3'b100 || wr_count !== wr_start) begin
            failures++;
            $display("FAIL trailing_byte done/hold/err=%b writes=%0d required=100/0", {done, cpu_hold, error}, wr_count - wr_start);
        end
`endif
    endtask

    task automatic test_bad_count();
        do_reset();
        wr_start = wr_count;
        send_byte(8'hA5);
        send_byte(8'h01);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL oversize_early err=%b required=0", error);
        end
        send_byte(8'h02);
        checks++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            failures++;
            $display("FAIL oversize_status done/hold/err=%b required=011", {done, cpu_hold, error});
        end
        send_byte(8'hA5);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL error_clear err=%b required=0", error);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            failures++;
            $display("FAIL zero_count_status done/hold/err=%b required=011", {done, cpu_hold, error});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_count !== wr_start) begin
            failures++;
            $display("FAIL bad_count_writes writes=%0d required=0", wr_count - wr_start);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        send_q(0);
        run_two_word("b2b", 0, 8'h90, 1'b1);
    endtask

    task automatic test_max_count();
        do_reset();
        wr_start = wr_count;
        add_header(16'd512);
        for (int i = 0; i < 512; i++) add_word($urandom, i);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(xsum);
`endif
        send_q(0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, cpu_hold, error} !== 3'b100 || wr_count - wr_start !== 512 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL max_count done/hold/err=%b writes=%0d required=100/512", {done, cpu_hold, error}, wr_count - wr_start);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        wr_start = wr_count;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
        send_q(1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, done, cpu_hold, error} !== {1'b0, BASE, 32'h0, 3'b010}) begin
            failures++;
            $display("FAIL async_reset we/addr/data/status=%b/%h/%h/%b required=0/%h/0/010",
                     imem_we, imem_addr, imem_wdata, {done, cpu_hold, error}, BASE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_header(16'd1);
        add_word(32'hDEAD_BEEF, 0);
        tx_q.push_back(8'h22);
        send_q(1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, cpu_hold, error} !== 3'b100 || wr_count - wr_start !== 1 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL reload done/hold/err=%b writes=%0d required=100/1", {done, cpu_hold, error}, wr_count - wr_start);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_bad_count();
        test_back_to_back();
        test_max_count();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
